// File: rtl/logic_reduce_if.sv
// Stream bundle for logic_reduce: input word handshake and per-frame result handshake.
// slave = reduction unit side, master = producer/consumer side; out_count only with LOGIC_REDUCE_COUNT_EN.
interface logic_reduce_if #(
    parameter int WIDTH = 8
`ifdef LOGIC_REDUCE_COUNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef LOGIC_REDUCE_COUNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    modport slave (
        input  in_valid, in_data, in_last, op, out_ready,
`ifdef LOGIC_REDUCE_COUNT_EN
        output out_count,
`endif
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_last, op, out_ready,
`ifdef LOGIC_REDUCE_COUNT_EN
        input  out_count,
`endif
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/logic_reduce.sv
// Streaming bitwise reduction: folds each framed word stream with AND/OR/XOR/NAND into one result.
// Ports: clk, rst (sync, active-high), bus (logic_reduce_if.slave); LOGIC_REDUCE_COUNT_EN adds out_count.
module logic_reduce #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    logic_reduce_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_d, out_data_q;
    logic [1:0]       op_q, op_eff;
    logic             take, first, last_take;

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("logic_reduce: WIDTH and CNT_W must be >= 1");
    end

    // Result leaving HOLD frees the unit in the same cycle.
    assign bus.in_ready  = (state_q != HOLD) || bus.out_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_data_q;

    assign take      = bus.in_valid && bus.in_ready;
    // Any accepted beat outside ACC opens a frame (IDLE, or HOLD while draining).
    assign first     = take && (state_q != ACC);
    assign last_take = take && bus.in_last;
    assign op_eff    = first ? bus.op : op_q;

    always_comb begin
        acc_d = acc_q;
        if (first) begin
            acc_d = bus.in_data;
        end else begin
            unique case (1'b1)
                op_q == 2'b01: acc_d = acc_q | bus.in_data;
                op_q == 2'b10: acc_d = acc_q ^ bus.in_data;
                default:       acc_d = acc_q & bus.in_data;
            endcase
        end
        // NAND folds as AND and inverts once at the end.
        res_d = (op_eff == 2'b11) ? ~acc_d : acc_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACC: begin
                if (last_take)
                    state_d = HOLD;
                else if (take)
                    state_d = ACC;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (last_take)
                        state_d = HOLD;
                    else if (take)
                        state_d = ACC;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            op_q       <= 2'b00;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (take)
                acc_q <= acc_d;
            if (first)
                op_q <= bus.op;
            if (last_take)
                out_data_q <= res_d;
        end
    end

`ifdef LOGIC_REDUCE_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q;

    always_comb begin
        cnt_d = cnt_q;
        if (first)
            cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_count_q <= '0;
        end else begin
            if (take)
                cnt_q <= cnt_d;
            if (last_take)
                out_count_q <= cnt_d;
        end
    end

    assign bus.out_count = out_count_q;
`endif
endmodule

// File: tb/tb_logic_reduce.sv
// Self-checking bench for logic_reduce: directed cases plus random frames vs a frame-level model.
// Model keeps beats of the open frame in a queue and folds them when the last beat is accepted.
module tb_logic_reduce;
    localparam int W = 8;
`ifdef LOGIC_REDUCE_COUNT_EN
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
`endif

    typedef struct {
        logic [W-1:0] data;
        int           cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [W-1:0] beats[$];
    logic [1:0]   m_op;
    exp_t         m_q[$];

`ifdef LOGIC_REDUCE_COUNT_EN
    logic_reduce_if #(.WIDTH(W), .CNT_W(CNT_W)) bus ();
    logic_reduce #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    logic_reduce_if #(.WIDTH(W)) bus ();
    logic_reduce #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fold(input logic [1:0] o);
        logic [W-1:0] r;
        r = beats[0];
        for (int i = 1; i < beats.size(); i++) begin
            case (o)
                2'b01:   r = r | beats[i];
                2'b10:   r = r ^ beats[i];
                default: r = r & beats[i];
            endcase
        end
        return (o == 2'b11) ? ~r : r;
    endfunction

    function automatic int sat_cnt(input int n);
`ifdef LOGIC_REDUCE_COUNT_EN
        return (n > CMAX) ? CMAX : n;
`else
        return n;
`endif
    endfunction

    // One clock: drive at negedge, check outputs, then predict the next edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic l,
                         input logic [1:0] o, input logic r);
        logic m_rdy;
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.op        = o;
        bus.out_ready = r;
        #1;
        m_rdy = (m_q.size() == 0) || r;
        check("in_ready", 32'(bus.in_ready), 32'(m_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("out_data", 32'(bus.out_data), 32'(m_q[0].data));
`ifdef LOGIC_REDUCE_COUNT_EN
            check("out_count", 32'(bus.out_count), 32'(m_q[0].cnt));
`endif
        end
        if (m_q.size() != 0 && r)
            void'(m_q.pop_front());
        if (v && m_rdy) begin
            if (beats.size() == 0)
                m_op = o;
            beats.push_back(d);
            if (l) begin
                e.data = fold(m_op);
                e.cnt  = sat_cnt(beats.size());
                m_q.push_back(e);
                beats.delete();
            end
        end
    endtask

    task automatic peek(input string tag, input logic [W-1:0] val, input int cnt);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(val));
`ifdef LOGIC_REDUCE_COUNT_EN
        check({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
`else
        if (cnt < 0)
            check({tag, "_cnt_arg"}, 32'(cnt), 32'd0);
`endif
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef LOGIC_REDUCE_COUNT_EN
        check("rst_out_count", 32'(bus.out_count), 32'd0);
`endif
        beats.delete();
        m_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (2) cycle(1'b0, '0, 1'b0, 2'b00, 1'b1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.op        = 2'b00;
        bus.out_ready = 1'b0;
        m_op = 2'b00;

        do_reset(2);
        repeat (3) cycle(1'b0, 8'hAA, 1'b1, 2'b01, 1'b1);

        cycle(1'b1, 8'hF0, 1'b0, 2'b00, 1'b1);
        cycle(1'b1, 8'h3C, 1'b0, 2'b00, 1'b1);
        cycle(1'b1, 8'hFF, 1'b1, 2'b00, 1'b1);
        peek("and", 8'h30, 3);

        cycle(1'b1, 8'hA5, 1'b1, 2'b11, 1'b1);
        peek("nand1", 8'h5A, 1);

        cycle(1'b1, 8'h0F, 1'b0, 2'b10, 1'b1);
        cycle(1'b1, 8'hF0, 1'b1, 2'b10, 1'b0);
        peek("xor", 8'hFF, 2);
        repeat (3) cycle(1'b1, 8'h55, 1'b0, 2'b00, 1'b0);
        cycle(1'b1, 8'h01, 1'b1, 2'b01, 1'b1);
        peek("simul", 8'h01, 1);
        drain();

        cycle(1'b1, 8'h10, 1'b0, 2'b01, 1'b1);
        cycle(1'b1, 8'h01, 1'b1, 2'b00, 1'b1);
        peek("opchg", 8'h11, 2);
        drain();

        cycle(1'b1, 8'hFF, 1'b0, 2'b00, 1'b1);
        cycle(1'b1, 8'h0F, 1'b0, 2'b00, 1'b1);
        do_reset(1);
        cycle(1'b1, 8'h80, 1'b1, 2'b01, 1'b1);
        peek("rstmid", 8'h80, 1);
        drain();

        for (int i = 0; i < 4; i++)
            cycle(1'b1, 8'hFF, 1'b0, 2'b00, 1'b1);
        cycle(1'b1, 8'hFF, 1'b1, 2'b00, 1'b1);
`ifdef LOGIC_REDUCE_COUNT_EN
        peek("sat", 8'hFF, CMAX);
`else
        peek("sat", 8'hFF, 5);
`endif
        drain();

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 10) < 7, W'($urandom), ($urandom % 4) == 0,
                  2'($urandom), ($urandom % 10) < 6);
        end
        repeat (4) cycle(1'b0, '0, 1'b0, 2'b00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/logic_reduce.md
# logic_reduce

Streaming, parametrised bitwise reduction unit: the sequential successor to the two-input gate primitives. It accepts a framed stream of WIDTH-bit words over a valid/ready handshake. It reduces every word in the frame with a selectable AND/OR/XOR/NAND operation and presents one registered result per frame on a valid/ready output. It sits between a word-stream producer and any consumer that needs a per-frame bitwise summary, such as a mask merge or parity check.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- CNT_W, 16, beat-counter width; used only when LOGIC_REDUCE_COUNT_EN is defined

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  unit can accept a word this cycle
- in_data  in  WIDTH  input word
- in_last  in  1  word is the final beat of the frame
- op  in  2  00 AND, 01 OR, 10 XOR, 11 NAND; sampled on first beat of a frame only
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- out_data  out  WIDTH  frame result
- out_count  out  CNT_W  beats in frame (only with LOGIC_REDUCE_COUNT_EN)

## Operation
- Accept: a beat is accepted when in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- States:
  - IDLE: no frame open.
  - ACC: frame open, result not yet produced.
  - HOLD: result valid, waiting for out_ready.
- IDLE: an accepted beat sets acc <= in_data and latches op into op_q.
  - in_last=1: go to HOLD.
  - in_last=0: go to ACC.
- ACC: an accepted beat sets acc <= acc OP in_data. OP is AND for op_q 00/11, OR for 01, XOR for 10.
  - Stay in ACC until a beat with in_last=1 is accepted, then go to HOLD.
- Result: out_data <= final acc. For op_q=11 the result is ~acc, i.e. NAND of all words.
- A single-beat frame yields in_data. With op=11 it yields ~in_data.
- HOLD: out_valid=1 and out_data is stable until transfer.
  - Transfer with no beat accepted: go to IDLE.
- in_ready = (state != HOLD) || out_ready. This is combinational; out_ready has the only combinational path to an output.
- Simultaneous event in HOLD: if out_ready=1 and in_valid=1 in the same cycle, the result transfers and the beat opens a new frame.
  - That beat is handled as an IDLE first beat, including the op sample and the single-beat case.
- op changes during ACC/HOLD are ignored.
- No timeout. A frame stays open indefinitely while no beats arrive.

## Timing
- Reset values:
  - state IDLE, acc 0, op_q 00.
  - out_valid 0, out_data 0, out_count 0.
  - in_ready 1 on the first cycle after reset.
- Reset while in ACC or HOLD discards the partial frame and any pending result. No output is produced for it.
- Latency: out_valid rises on the cycle after the edge that accepts the in_last beat. That is 1 cycle.
- Throughput: one beat per cycle while in IDLE and ACC.
  - Back-to-back single-beat frames sustain 1 per cycle only when out_ready is held high.
- out_data and out_count change only on the edge that enters HOLD.

## Configuration
- LOGIC_REDUCE_COUNT_EN defined:
  - out_count port exists.
  - It is loaded with the number of beats accepted in the frame when HOLD is entered.
  - The internal counter is reset to 1 on each first beat and saturates at 2^CNT_W−1.
- Undefined: out_count port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then idle (WIDTH=8):
  - rst high 2 cycles -> out_valid=0, out_data=8'h00, in_ready=1.
  - No output while in_valid=0.
- AND frame, op=00, beats F0, 3C, FF(last), out_ready=1 -> out_data=8'h30 one cycle after last; out_count=3 (macro on).
- Single-beat NAND, op=11, beat A5 with last -> out_data=8'h5A; out_count=1.
- Backpressure plus simultaneous event:
  - XOR frame 0F, F0(last) with out_ready=0 -> out_data=8'hFF held; in_ready=0 for 3 cycles.
  - Then out_ready=1 with OR beat 01(last) in the same cycle -> FF transfers, next result 8'h01.
- op change mid-frame: op=01 on beat 10, op=00 on beat 01(last) -> out_data=8'h11 (OR retained).
- Reset mid-frame: AND beats FF, 0F (no last), rst 1 cycle, then OR beat 80(last) -> out_data=8'h80; no earlier output.
- Saturation (macro on, CNT_W=2): 5-beat frame -> out_count=3.
